gray_fifo_drain: RTL and testbench

- Bus-master stage directly downstream of the bin2gray FIFO peripheral.
- Polls the peripheral's CTL_STAT register (addr 3) and pops Gray-coded words from addr 0 while the FIFO is non-empty.
- Decodes each popped word back to binary and presents it on a valid/ready output stream.
- Flags FIFO overflow and underflow status as a sticky error.

---
 rtl/gray_fifo_drain.sv | 202 ++++++++++++++++++++
 tb/tb_gray_fifo_drain.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_fifo_drain.sv
// gray_fifo_drain: bus master that drains a Gray-coded FIFO peripheral.
// Polls CTL_STAT (addr 3), pops words from addr 0 while the FIFO is
// non-empty, decodes them to binary and presents them on a valid/ready
// stream. Overflow/underflow status or an error response sets a sticky err.
// Optional feature: define GRAY_FIFO_DRAIN_CNT_EN to add a 16-bit
// drain_cnt output counting delivered words.
// DATA_W must be at least 4 so the CTL_STAT flag bits exist.
//
// Stream handshake: m_data is valid while m_valid=1 and stays stable until
// the cycle where m_valid&m_ready are both high; that cycle transfers the
// word and m_valid drops on the following cycle.
module gray_fifo_drain #(
  parameter int DATA_W   = 8,
  parameter int POLL_GAP = 4,
  parameter int RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              p_enable,
  output logic [1:0]        p_addr,
  output logic              p_write,
  output logic              p_read,
  output logic [DATA_W-1:0] p_wdata,
  input  logic [DATA_W-1:0] p_rdata,
  input  logic              p_resp,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              err,
  input  logic              err_clr
`ifdef GRAY_FIFO_DRAIN_CNT_EN
  ,
  output logic [15:0]       drain_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_POLL = 3'd1,
    S_GAP  = 3'd2,
    S_POP  = 3'd3,
    S_WAIT = 3'd4,
    S_OUT  = 3'd5
  } state_e;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_STAT = 2'd3;
  localparam logic [7:0] GAP_INIT  = 8'(POLL_GAP);
  localparam logic [1:0] LAT_INIT  = 2'(RD_LAT);

  state_e              state_q, state_d;
  logic [7:0]          gap_q, gap_d;
  logic [1:0]          lat_q, lat_d;
  logic [DATA_W-1:0]   cap_q, cap_d;
  logic                m_valid_q, m_valid_d;
  logic                err_q, err_d;
  logic                err_set;
  logic                p_enable_q, p_enable_d;
  logic [1:0]          p_addr_q, p_addr_d;
  logic                p_read_q, p_read_d;
`ifdef GRAY_FIFO_DRAIN_CNT_EN
  logic [15:0]         cnt_q, cnt_d;
`endif

  // Gray to binary: each binary bit is the XOR of itself and all higher Gray bits.
  function automatic logic [DATA_W-1:0] gray2bin(input logic [DATA_W-1:0] g);
    logic [DATA_W-1:0] b;
    b = '0;
    b[DATA_W-1] = g[DATA_W-1];
    for (int i = DATA_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Next-state logic. The gap and latency counters reach 0 on the edge that
  // leaves GAP/WAIT, so a counter loaded with N keeps the FSM there N cycles.
  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    lat_d     = lat_q;
    cap_d     = cap_q;
    m_valid_d = m_valid_q;
    err_set   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_POLL;
      end
      S_POLL: begin
        // Status is sampled in the access cycle itself.
        if (p_rdata[2] || p_rdata[3] || p_resp) err_set = 1'b1;
        if (!p_rdata[0]) begin
          state_d = S_POP;
        end else if (POLL_GAP == 0) begin
          state_d = S_POLL;
        end else begin
          state_d = S_GAP;
          gap_d   = GAP_INIT;
        end
      end
      S_GAP: begin
        if (gap_q <= 8'd1) begin
          gap_d   = 8'd0;
          state_d = run ? S_POLL : S_IDLE;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      S_POP: begin
        if (RD_LAT == 0) begin
          cap_d     = p_rdata;
          m_valid_d = 1'b1;
          state_d   = S_OUT;
        end else begin
          lat_d   = LAT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (lat_q <= 2'd1) begin
          lat_d     = 2'd0;
          cap_d     = p_rdata;
          m_valid_d = 1'b1;
          state_d   = S_OUT;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      S_OUT: begin
        // No bus traffic here: holding in OUT back-pressures the FIFO.
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = run ? S_POLL : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new error in the same cycle as a clear must not be lost.
    if (err_set)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err_q;

    // Bus outputs are registered, so they are derived from the next state.
    p_enable_d = (state_d == S_POLL) || (state_d == S_POP);
    p_addr_d   = (state_d == S_POLL) ? ADDR_STAT : ADDR_DATA;
    p_read_d   = p_enable_d;

`ifdef GRAY_FIFO_DRAIN_CNT_EN
    if (err_clr)                   cnt_d = 16'd0;
    else if (m_valid_q && m_ready) cnt_d = cnt_q + 16'd1;
    else                           cnt_d = cnt_q;
`endif
  end

  // State and registered outputs; reset drops any undelivered word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      gap_q      <= 8'd0;
      lat_q      <= 2'd0;
      cap_q      <= '0;
      m_valid_q  <= 1'b0;
      err_q      <= 1'b0;
      p_enable_q <= 1'b0;
      p_addr_q   <= 2'd0;
      p_read_q   <= 1'b0;
`ifdef GRAY_FIFO_DRAIN_CNT_EN
      cnt_q      <= 16'd0;
`endif
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      lat_q      <= lat_d;
      cap_q      <= cap_d;
      m_valid_q  <= m_valid_d;
      err_q      <= err_d;
      p_enable_q <= p_enable_d;
      p_addr_q   <= p_addr_d;
      p_read_q   <= p_read_d;
`ifdef GRAY_FIFO_DRAIN_CNT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign p_enable = p_enable_q;
  assign p_addr   = p_addr_q;
  assign p_read   = p_read_q;
  assign p_write  = 1'b0;
  assign p_wdata  = '0;
  assign m_data   = gray2bin(cap_q);
  assign m_valid  = m_valid_q;
  assign busy     = (state_q != S_IDLE);
  assign err      = err_q;
`ifdef GRAY_FIFO_DRAIN_CNT_EN
  assign drain_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_gray_fifo_drain.sv
// Testbench for gray_fifo_drain: a peripheral model with a Gray-word FIFO,
// a scoreboard of expected decoded words, and a protocol/timing monitor.
module tb_gray_fifo_drain;
  localparam int DATA_W   = 8;
  localparam int POLL_GAP = 4;
  localparam int RD_LAT   = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              run = 1'b0;
  logic              p_enable;
  logic [1:0]        p_addr;
  logic              p_write;
  logic              p_read;
  logic [DATA_W-1:0] p_wdata;
  logic [DATA_W-1:0] p_rdata = '0;
  logic              p_resp = 1'b0;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic              busy;
  logic              err;
  logic              err_clr = 1'b0;
`ifdef GRAY_FIFO_DRAIN_CNT_EN
  logic [15:0]       drain_cnt;
`endif

  gray_fifo_drain #(.DATA_W(DATA_W), .POLL_GAP(POLL_GAP), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .p_enable(p_enable), .p_addr(p_addr), .p_write(p_write), .p_read(p_read),
    .p_wdata(p_wdata), .p_rdata(p_rdata), .p_resp(p_resp),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .err(err), .err_clr(err_clr)
`ifdef GRAY_FIFO_DRAIN_CNT_EN
    , .drain_cnt(drain_cnt)
`endif
  );

  // ---------------- clock ----------------
  initial forever #5 clk = ~clk;

  // ---------------- shared state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] fifo[$];    // Gray words waiting in the peripheral
  logic [DATA_W-1:0] exp_q[$];   // expected decoded words, in order
  logic [3:0] inj_stat = '0;     // flag bits forced on the next poll
  logic       inj_resp = 1'b0;   // error response forced on the next poll
  int n_poll = 0, n_pop = 0, n_hs = 0;
  logic [DATA_W-1:0] last_hs_data = '0;

  // monitor trackers
  int cyc = 0;
  int gap_start = -1, ne_cyc = -1, pop_cyc = -1000;
  logic gap_run = 1'b0;
  logic [DATA_W-1:0] pop_word = '0;
  logic prev_mvalid = 1'b0, prev_mready = 1'b0, prev_hs = 1'b0, prev_run = 1'b0;
  logic [DATA_W-1:0] prev_mdata = '0;
  logic exp_err = 1'b0;
  logic [15:0] exp_cnt = '0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endfunction

  // Reference decode: binary bit i is the parity of Gray bits i and above.
  function automatic logic [DATA_W-1:0] ref_decode(input logic [DATA_W-1:0] g);
    logic [DATA_W-1:0] b;
    b = '0;
    for (int k = 0; k < DATA_W; k++) b = b ^ (g >> k);
    return b;
  endfunction

  // ---------------- peripheral model + monitor (negedge) ----------------
  initial begin : periph_mon
    logic acc, is_poll, is_pop, hs_now, err_set;
    logic [DATA_W-1:0] stat, word;
    int d;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        exp_q.delete();
        gap_start = -1; ne_cyc = -1; pop_cyc = -1000;
        prev_mvalid = 1'b0; prev_mready = 1'b0; prev_hs = 1'b0;
        exp_err = 1'b0; exp_cnt = '0;
        p_rdata = DATA_W'($urandom); p_resp = 1'b0;
        continue;
      end
      acc     = p_enable;
      is_poll = acc && (p_addr == 2'd3);
      is_pop  = acc && (p_addr == 2'd0);
      hs_now  = m_valid && m_ready;

      check("err_model", err, exp_err);
`ifdef GRAY_FIFO_DRAIN_CNT_EN
      check("drain_cnt_model", drain_cnt, exp_cnt);
`endif
      if (acc) begin
        check("acc_read", p_read, 1);
        check("acc_addr", (p_addr == 2'd0) || (p_addr == 2'd3), 1);
        check("acc_nowrite", {p_write, p_wdata}, 0);
      end
      if (m_valid) check("no_access_in_out", acc, 0);
      if (prev_mvalid && !prev_mready) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, prev_mdata);
      end
      if (prev_hs) begin
        check("valid_drop", m_valid, 0);
        if (prev_run) check("poll_after_hs", is_poll, 1);
        else          check("idle_after_hs", {acc, busy}, 0);
      end
      if (gap_start >= 0) begin
        d = cyc - gap_start;
        if (d <= POLL_GAP) check("gap_quiet", acc, 0);
        if (d == POLL_GAP) gap_run = run;
        if (d == POLL_GAP + 1) begin
          if (POLL_GAP == 0 || gap_run) check("gap_repoll", is_poll, 1);
          else                          check("gap_to_idle", {acc, busy}, 0);
          gap_start = -1;
        end
      end
      if (ne_cyc >= 0) begin
        d = cyc - ne_cyc;
        if (d == 1) check("pop_after_poll", is_pop, 1);
        if (d >= 2 && d <= RD_LAT + 1) check("valid_early", m_valid, 0);
        if (d == RD_LAT + 2) begin
          check("valid_latency", m_valid, 1);
          ne_cyc = -1;
        end
      end
      if (hs_now) begin
        n_hs++;
        last_hs_data = m_data;
        if (exp_q.size() == 0) check("sb_unexpected_word", m_data, 'hDEAD);
        else check("sb_data", m_data, exp_q.pop_front());
      end

      // peripheral response for this cycle
      err_set = 1'b0;
      p_rdata = DATA_W'($urandom);
      p_resp  = 1'($urandom_range(0, 1));
      if (is_pop) begin
        n_pop++;
        check("pop_nonempty", fifo.size() > 0, 1);
        if (fifo.size() > 0) begin
          word = fifo.pop_front();
          exp_q.push_back(ref_decode(word));
          pop_word = word;
          pop_cyc  = cyc;
        end
      end
      if (is_poll) begin
        n_poll++;
        stat = DATA_W'($urandom);
        stat[3:0] = {inj_stat[3:2], fifo.size() >= 16, fifo.size() == 0};
        p_rdata  = stat;
        p_resp   = inj_resp;
        err_set  = stat[2] || stat[3] || inj_resp;
        inj_stat = '0;
        inj_resp = 1'b0;
        if (stat[0]) gap_start = cyc;
        else         ne_cyc = cyc;
      end else if (cyc == pop_cyc + RD_LAT) begin
        p_rdata = pop_word;
      end

      if (err_set)      exp_err = 1'b1;
      else if (err_clr) exp_err = 1'b0;
      if (err_clr)     exp_cnt = '0;
      else if (hs_now) exp_cnt = exp_cnt + 16'd1;
      prev_mvalid = m_valid; prev_mready = m_ready; prev_mdata = m_data;
      prev_hs = hs_now; prev_run = run;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(input int target, input int budget, input string name);
    int k = 0;
    while (n_hs < target && k < budget) begin step(); k++; end
    check(name, n_hs >= target, 1);
  endtask

  task automatic wait_valid(input int budget, input string name);
    int k = 0;
    while (!m_valid && k < budget) begin step(); k++; end
    check(name, m_valid, 1);
  endtask

  task automatic wait_inj_used(input int budget, input string name);
    int k = 0;
    while ((inj_stat != 0 || inj_resp) && k < budget) begin step(); k++; end
    check(name, (inj_stat == 0) && !inj_resp, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int p0, q0, h0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_p_enable", p_enable, 0);
    check("rst_p_addr", p_addr, 0);
    check("rst_p_read", p_read, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
`ifdef GRAY_FIFO_DRAIN_CNT_EN
    check("rst_drain_cnt", drain_cnt, 0);
`endif
    step();
    rst_n = 1'b1;

    // empty FIFO: polls every POLL_GAP+1 cycles, never a pop
    run = 1'b1; m_ready = 1'b1;
    p0 = n_poll; q0 = n_pop;
    repeat (40) step();
    check("empty_poll_count", n_poll - p0, (40 - 1) / (POLL_GAP + 1) + 1);
    check("empty_no_pop", n_pop - q0, 0);

    // single word
    h0 = n_hs;
    fifo.push_back(8'h77);
    wait_hs(h0 + 1, 60, "single_word_timeout");
    check("single_word_data", last_hs_data, 8'h5A);

    // back-pressure
    m_ready = 1'b0;
    fifo.push_back(8'hFF);
    wait_valid(60, "bp_valid_timeout");
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_valid", m_valid, 1);
      check("bp_hold_data", m_data, 8'hAA);
      check("bp_no_bus", p_enable, 0);
      step();
    end
    m_ready = 1'b1;
    step();
    check("bp_next_poll", {p_enable, p_addr, m_valid}, {1'b1, 2'd3, 1'b0});

    // error flags and clear
    repeat (10) step();
    inj_stat = 4'h8;
    wait_inj_used(40, "err_poll_timeout");
    check("err_set_ovf", err, 1);
    repeat (12) step();
    check("err_persists", err, 1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    check("err_cleared", err, 0);
    err_clr = 1'b1; inj_stat = 4'h4;
    wait_inj_used(40, "err_clr_poll_timeout");
    err_clr = 1'b0;
    check("err_set_wins", err, 1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    check("err_cleared2", err, 0);
    inj_resp = 1'b1;
    wait_inj_used(40, "resp_poll_timeout");
    check("err_set_resp", err, 1);
    err_clr = 1'b1; step(); err_clr = 1'b0;

    // run dropped during WAIT
    q0 = n_pop; h0 = n_hs;
    fifo.push_back(8'h3C);
    while (n_pop == q0 && cyc < 100000) step();
    run = 1'b0;
    wait_hs(h0 + 1, 20, "run_drop_timeout");
    repeat (2) step();
    for (int i = 0; i < 8; i++) begin
      check("run_drop_idle", {busy, p_enable}, 0);
      step();
    end
    check("run_drop_sb_empty", exp_q.size(), 0);

    // reset during OUT
    run = 1'b1; m_ready = 1'b0;
    fifo.push_back(8'hC3);
    wait_valid(60, "rst_out_timeout");
    check("rst_out_pending", exp_q.size(), 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", m_valid, 0);
    check("async_rst_enable", p_enable, 0);
    check("async_rst_busy", busy, 0);
    step(); step();
    rst_n = 1'b1; m_ready = 1'b1;

`ifdef GRAY_FIFO_DRAIN_CNT_EN
    h0 = n_hs;
    fifo.push_back(8'h01); fifo.push_back(8'h80); fifo.push_back(8'h55);
    wait_hs(h0 + 3, 200, "cnt_timeout");
    step();
    check("drain_cnt_three", drain_cnt, 3);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("drain_cnt_reset", drain_cnt, 0);
    step();
    rst_n = 1'b1;
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (fifo.size() < 16 && $urandom_range(0, 3) == 0) fifo.push_back(DATA_W'($urandom));
      m_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 19) == 0) run = ~run;
      if (inj_stat == 0 && $urandom_range(0, 39) == 0) inj_stat = 4'($urandom_range(1, 3) << 2);
      if (!inj_resp && $urandom_range(0, 59) == 0) inj_resp = 1'b1;
      err_clr = ($urandom_range(0, 29) == 0);
      step();
    end

    // drain everything
    run = 1'b1; m_ready = 1'b1; err_clr = 1'b0;
    for (int k = 0; k < 600 && (fifo.size() != 0 || exp_q.size() != 0 || m_valid); k++) step();
    check("final_fifo_empty", fifo.size(), 0);
    check("final_sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
